// File: rtl/cube_pkg.sv
// Shared cube move types: face encoding, move record and rotation inverse helper.
package cube_pkg;

  localparam int unsigned FACE_W = 6;
  localparam int unsigned ROT_W  = 2;

  typedef enum logic [FACE_W-1:0] {
    FACE_U = 6'd0,
    FACE_L = 6'd1,
    FACE_F = 6'd2,
    FACE_R = 6'd3,
    FACE_B = 6'd4,
    FACE_D = 6'd5
  } face_t;

  typedef struct packed {
    logic [FACE_W-1:0] face;
    logic [ROT_W-1:0]  rot;
  } move_t;

  // Quarter turns that undo rot: (4 - rot) mod 4
  function automatic logic [ROT_W-1:0] inv_rot(input logic [ROT_W-1:0] rot);
    return ~rot + ROT_W'(1);
  endfunction

endpackage

// File: rtl/cube_move_lifo.sv
// Circular move history: push/pop/replace at the top; the oldest entry is overwritten when full.
module cube_move_lifo
  import cube_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             replace_i,
  input  move_t            wdata_i,
  output move_t            top_c,
  output move_t            next_c,
  output logic             evict_c,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  move_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  top_idx, next_idx;
  logic              full, empty;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign top_idx  = wr_ptr_q - PTR_W'(1);
  assign next_idx = wr_ptr_q - PTR_W'(2);
  assign top_c    = mem_q[top_idx];
  assign next_c   = mem_q[next_idx];
  assign evict_c  = push_i & ~clear_i & full;
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty) begin
      wr_ptr_d = top_idx;
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count==0 makes every entry unreachable
  always_ff @(posedge clk) begin
    if (!clear_i) begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end else if (replace_i && !empty) begin
        mem_q[top_idx] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/cube_move_undo.sv
// Move history with LIFO undo of inverse moves to the cube mover over a valid/ready handshake.
// Optional MOVE_MERGE_EN folds a record on the same face as the top entry into that entry.
module cube_move_undo
  import cube_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rec_valid,
  input  logic [FACE_W-1:0] rec_face,
  input  logic [ROT_W-1:0]  rec_rot,
  output logic              rec_ready,
  input  logic              undo_req,
  input  logic              undo_all,
  output logic              mv_valid,
  output logic [FACE_W-1:0] mv_face,
  output logic [ROT_W-1:0]  mv_rot,
  input  logic              mv_ready,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              lost
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              mv_valid_q, mv_valid_d;
  logic [FACE_W-1:0] mv_face_q, mv_face_d;
  logic [ROT_W-1:0]  mv_rot_q, mv_rot_d;
  logic              all_mode_q, all_mode_d;
  logic              lost_q, lost_d;

  logic              l_clear, l_push, l_pop, l_replace, evict;
  move_t             l_wdata, top, next;
  logic              rec_fire, merge_hit;
  logic [ROT_W-1:0]  merge_sum;

  cube_move_lifo #(.DEPTH(DEPTH)) u_lifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (l_clear),
    .push_i    (l_push),
    .pop_i     (l_pop),
    .replace_i (l_replace),
    .wdata_i   (l_wdata),
    .top_c     (top),
    .next_c    (next),
    .evict_c   (evict),
    .count_o   (count)
  );

  assign rec_ready = (state_q == S_IDLE) & ~undo_req & ~undo_all & ~clr;
  assign rec_fire  = rec_valid & rec_ready & (rec_rot != '0) &
                     (rec_face <= FACE_W'(FACE_D));
  assign merge_sum = top.rot + rec_rot;
`ifdef MOVE_MERGE_EN
  assign merge_hit = rec_fire & (count != '0) & (rec_face == top.face);
`else
  assign merge_hit = 1'b0;
`endif

  // Next-state, history control and output register loads
  always_comb begin
    state_d    = state_q;
    mv_valid_d = mv_valid_q;
    mv_face_d  = mv_face_q;
    mv_rot_d   = mv_rot_q;
    all_mode_d = all_mode_q;
    lost_d     = lost_q;
    l_clear    = 1'b0;
    l_push     = 1'b0;
    l_pop      = 1'b0;
    l_replace  = 1'b0;
    l_wdata    = '{face: rec_face, rot: rec_rot};
    if (state_q == S_IDLE) begin
      if (clr) begin
        l_clear = 1'b1;
        lost_d  = 1'b0;
      end else if ((undo_all || undo_req) && (count != '0)) begin
        state_d    = S_PRESENT;
        mv_valid_d = 1'b1;
        mv_face_d  = top.face;
        mv_rot_d   = inv_rot(top.rot);
        all_mode_d = undo_all;
      end else if (rec_fire) begin
        if (merge_hit) begin
          if (merge_sum == '0) begin
            l_pop = 1'b1;
          end else begin
            l_replace   = 1'b1;
            l_wdata.rot = merge_sum;
          end
        end else begin
          l_push = 1'b1;
          if (evict) lost_d = 1'b1;
        end
      end
    end else if (mv_ready) begin
      l_pop = 1'b1;
      if (all_mode_q && (count > CNT_W'(1))) begin
        mv_face_d = next.face;
        mv_rot_d  = inv_rot(next.rot);
      end else begin
        mv_valid_d = 1'b0;
        all_mode_d = 1'b0;
        state_d    = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mv_valid_q <= 1'b0;
      mv_face_q  <= '0;
      mv_rot_q   <= '0;
      all_mode_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_valid_q <= mv_valid_d;
      mv_face_q  <= mv_face_d;
      mv_rot_q   <= mv_rot_d;
      all_mode_q <= all_mode_d;
      lost_q     <= lost_d;
    end
  end

  assign mv_valid = mv_valid_q;
  assign mv_face  = mv_face_q;
  assign mv_rot   = mv_rot_q;
  assign busy     = state_q[0];
  assign lost     = lost_q;

endmodule

// File: tb/tb_cube_move_undo.sv
// Scoreboard bench for cube_move_undo: expected inverse moves are queued, a monitor checks handshakes.
module tb_cube_move_undo;
  import cube_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              clk, rst_n, clr;
  logic              rec_valid, rec_ready;
  logic [FACE_W-1:0] rec_face;
  logic [ROT_W-1:0]  rec_rot;
  logic              undo_req, undo_all;
  logic              mv_valid, mv_ready;
  logic [FACE_W-1:0] mv_face;
  logic [ROT_W-1:0]  mv_rot;
  logic [CNT_W-1:0]  count;
  logic              busy, lost;

  int                checks = 0;
  int                errors = 0;
  int                hs_cnt = 0;
  logic [7:0]        exp_q[$];
  logic [7:0]        exp_e;

  cube_move_undo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .rec_valid (rec_valid),
    .rec_face  (rec_face),
    .rec_rot   (rec_rot),
    .rec_ready (rec_ready),
    .undo_req  (undo_req),
    .undo_all  (undo_all),
    .mv_valid  (mv_valid),
    .mv_face   (mv_face),
    .mv_rot    (mv_rot),
    .mv_ready  (mv_ready),
    .count     (count),
    .busy      (busy),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_mv(input logic [FACE_W-1:0] f, input logic [ROT_W-1:0] r);
    exp_q.push_back({f, r});
  endtask

  task automatic record(input logic [FACE_W-1:0] f, input logic [ROT_W-1:0] r);
    rec_valid = 1'b1;
    rec_face  = f;
    rec_rot   = r;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic start_undo(input logic all);
    undo_req = ~all;
    undo_all = all;
    tick();
    undo_req = 1'b0;
    undo_all = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Stimulus with faces cycling U..D so consecutive records never share a face
  function automatic logic [FACE_W-1:0] seq_face(input int i);
    return FACE_W'(i % 6);
  endfunction
  function automatic logic [ROT_W-1:0] seq_rot(input int i);
    return ROT_W'((i % 3) + 1);
  endfunction
  function automatic logic [ROT_W-1:0] seq_inv(input int i);
    logic [ROT_W-1:0] r;
    r = seq_rot(i);
    return (r == 2'd1) ? 2'd3 : (r == 2'd3) ? 2'd1 : 2'd2;
  endfunction

  initial begin
    int n;
    int hs0;
    rst_n = 1'b0; clr = 1'b0; rec_valid = 1'b0; rec_face = '0; rec_rot = '0;
    undo_req = 1'b0; undo_all = 1'b0; mv_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && mv_valid && mv_ready) begin
          hs_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mv_unexpected: got face %0d rot %0d, expected none", mv_face, mv_rot);
          end else begin
            exp_e = exp_q.pop_front();
            if ({mv_face, mv_rot} !== exp_e) begin
              errors++;
              $display("FAIL mv_move: got face %0d rot %0d, expected face %0d rot %0d",
                       mv_face, mv_rot, exp_e[7:2], exp_e[1:0]);
            end
          end
        end
      end
    join_none

    #12 rst_n = 1'b1;
    tick();
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_mv_face", mv_face, 0);
    chk("rst_mv_rot", mv_rot, 0);
    chk("rst_count", count, 0);
    chk("rst_lost", lost, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rec_ready", rec_ready, 1);

    // Undo on empty history does nothing; undo blocks record readiness
    undo_req = 1'b1;
    #1 chk("rec_ready_undo", rec_ready, 0);
    tick();
    undo_req = 1'b0;
    chk("empty_undo_busy", busy, 0);

    // Test 1: single undos
    record(FACE_U, 2'd1); record(FACE_F, 2'd2); record(FACE_R, 2'd3);
    chk("t1_count3", count, 3);
    expect_mv(FACE_R, 2'd1);
    start_undo(1'b0);
    chk("t1_latency", mv_valid, 1);
    wait_idle(10, n);
    chk("t1_count2", count, 2);
    expect_mv(FACE_F, 2'd2);
    start_undo(1'b0);
    wait_idle(10, n);
    chk("t1_count1", count, 1);

    // clr together with undo: clr wins
    clr = 1'b1; undo_req = 1'b1;
    tick();
    clr = 1'b0; undo_req = 1'b0;
    chk("clr_undo_busy", busy, 0);
    chk("clr_undo_count", count, 0);

    // Test 2: undo_all back-to-back
    record(FACE_U, 2'd1); record(FACE_L, 2'd1); record(FACE_B, 2'd2);
    expect_mv(FACE_B, 2'd2); expect_mv(FACE_L, 2'd3); expect_mv(FACE_U, 2'd3);
    start_undo(1'b1);
    wait_idle(20, n);
    chk("t2_cycles", n, 3);
    chk("t2_count", count, 0);

    // Test 3: stall holds the presented move
    record(FACE_U, 2'd1);
    mv_ready = 1'b0;
    expect_mv(FACE_U, 2'd3);
    start_undo(1'b0);
    rec_valid = 1'b1; rec_face = FACE_B; rec_rot = 2'd1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", mv_valid, 1);
      chk("t3_face", mv_face, FACE_U);
      chk("t3_rot", mv_rot, 3);
      chk("t3_rec_ready", rec_ready, 0);
      tick();
    end
    rec_valid = 1'b0;
    chk("t3_count_hold", count, 1);
    mv_ready = 1'b1;
    wait_idle(10, n);
    chk("t3_count", count, 0);

    // Test 4: overflow evicts oldest entries and sets lost
    for (int i = 0; i < DEPTH + 2; i++) record(seq_face(i), seq_rot(i));
    chk("t4_count", count, DEPTH);
    chk("t4_lost", lost, 1);
    for (int i = DEPTH + 1; i >= 2; i--) expect_mv(seq_face(i), seq_inv(i));
    hs0 = hs_cnt;
    start_undo(1'b1);
    wait_idle(DEPTH + 10, n);
    chk("t4_moves", hs_cnt - hs0, DEPTH);
    chk("t4_count0", count, 0);
    chk("t4_lost_kept", lost, 1);
    do_clr();
    chk("t4_clr_lost", lost, 0);

    // Test 5: reset in the middle of undo_all
    record(FACE_U, 2'd1); record(FACE_L, 2'd1); record(FACE_F, 2'd1); record(FACE_R, 2'd1);
    mv_ready = 1'b0;
    start_undo(1'b1);
    expect_mv(FACE_R, 2'd3); expect_mv(FACE_F, 2'd3);
    mv_ready = 1'b1;
    tick();
    tick();
    mv_ready = 1'b0;
    chk("t5_count_mid", count, 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", mv_valid, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_queue", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    mv_ready = 1'b1;
    tick();

    // Test 6: same-face records, merged or stacked
`ifdef MOVE_MERGE_EN
    record(FACE_U, 2'd1); record(FACE_U, 2'd1);
    chk("t6_merge_count", count, 1);
    expect_mv(FACE_U, 2'd2);
    start_undo(1'b0);
    wait_idle(10, n);
    chk("t6_merge_count0", count, 0);
    record(FACE_U, 2'd1); record(FACE_U, 2'd3);
    chk("t6_cancel_count", count, 0);
`else
    record(FACE_U, 2'd1); record(FACE_U, 2'd1);
    chk("t6_stack_count", count, 2);
    expect_mv(FACE_U, 2'd3); expect_mv(FACE_U, 2'd3);
    start_undo(1'b1);
    wait_idle(10, n);
    chk("t6_stack_count0", count, 0);
`endif
    // Illegal records are ignored
    record(FACE_R, 2'd2);
    record(FACE_R, 2'd0);
    record(6'd6, 2'd1);
    chk("t6_illegal_count", count, 1);
    expect_mv(FACE_R, 2'd2);
    start_undo(1'b0);
    wait_idle(10, n);
    chk("t6_final_count", count, 0);

    tick();
    chk("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
